imem_boot_loader: RTL and testbench



---
 rtl/boot_pkg.sv | 30 +++
 rtl/boot_timeout_cnt.sv | 45 ++++
 rtl/imem_boot_loader.sv | 199 +++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// ---------------------------------------------------------------------------
// boot_pkg
// Shared types and constants for the instruction-memory boot loader:
//   - boot_state_t      : boot sequencer states
//   - SYNC_BYTE_DEFAULT : default frame start marker
//   - LEN_W / BIDX_W    : widths of the word-count field and byte-in-word index
//   - word_addr()       : byte address of instruction word <idx> from <base>
// ---------------------------------------------------------------------------
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CHECK,
        ST_RUN,
        ST_ERROR
    } boot_state_t;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned LEN_W             = 16;
    localparam int unsigned BIDX_W            = 2;

    function automatic logic [31:0] word_addr(input logic [31:0]      base,
                                              input logic [LEN_W-1:0] idx);
        return base + {14'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/boot_timeout_cnt.sv
// ---------------------------------------------------------------------------
// boot_timeout_cnt
// Inter-byte idle watchdog. Loadable down-counter that is reloaded with
// TIMEOUT_CYC on every received byte or on a clear, and counts down while
// enabled. o_expire flags the TIMEOUT_CYC-th consecutive idle enabled cycle.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (counter -> 0)
//   i_en     in   counting enabled (frame in progress)
//   i_reload in   byte received this cycle; restart the idle window
//   i_clear  in   restart the idle window (state change / not counting)
//   o_expire out  idle window exhausted this cycle
// ---------------------------------------------------------------------------
module boot_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_reload,
    input  logic i_clear,
    output logic o_expire
);

    localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || i_reload) begin
            r_cnt <= LOAD;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - ONE;
        end
    end

    // A loaded value of TIMEOUT_CYC reaches 1 on the TIMEOUT_CYC-th idle cycle.
    assign o_expire = i_en && !i_reload && (r_cnt == ONE);

endmodule

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Boot sequencer: holds the core in reset, receives a framed program image
// from the UART byte stream, writes it word by word into instruction memory,
// validates the XOR checksum and then releases the core.
// Frame: SYNC, LEN_LO, LEN_HI, N x 4 data bytes (little-endian), CHK.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   rx_valid   in   one-cycle strobe, rx_data holds a received byte
//   rx_data    in   received byte
//   imem_we    out  instruction memory write enable (one-cycle pulse)
//   imem_addr  out  write byte address, BASE_ADDR + 4*word index
//   imem_wdata out  assembled instruction word
//   core_rst_n out  active-low core reset, released only in RUN
//   boot_done  out  high in RUN
//   boot_err   out  high in ERROR
// ---------------------------------------------------------------------------
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst_n,
    output logic        boot_done,
    output logic        boot_err
);

    boot_state_t       r_state;
    boot_state_t       w_state_next;

    logic [7:0]        r_len_lo;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_word_idx;
    logic [BIDX_W-1:0] r_byte_idx;
    logic [23:0]       r_asm;
    logic [7:0]        r_xor;

    logic              r_we;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic              r_core_rst_n;
    logic              r_boot_done;
    logic              r_boot_err;

    logic              w_is_sync;
    logic [LEN_W-1:0]  w_len_rx;
    logic              w_last_byte;
    logic              w_last_word;
    logic              w_tmo_en;
    logic              w_tmo_clear;
    logic              w_tmo_expire;

    assign w_is_sync   = rx_valid && (rx_data == SYNC_BYTE);
    assign w_len_rx    = {rx_data, r_len_lo};
    assign w_last_byte = (r_byte_idx == BIDX_W'(3));
    assign w_last_word = (r_word_idx == (r_len - LEN_W'(1)));

    assign w_tmo_en    = (r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                         (r_state == ST_DATA) || (r_state == ST_CHECK);
    assign w_tmo_clear = !w_tmo_en || (w_state_next != r_state);

    boot_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_tmo_en),
        .i_reload (rx_valid),
        .i_clear  (w_tmo_clear),
        .o_expire (w_tmo_expire)
    );

    // Next-state logic. w_tmo_expire is already qualified by !rx_valid.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_is_sync) w_state_next = ST_LEN0;
            end
            ST_LEN0: begin
                if (rx_valid)          w_state_next = ST_LEN1;
                else if (w_tmo_expire) w_state_next = ST_ERROR;
            end
            ST_LEN1: begin
                if (rx_valid) begin
                    if ({16'b0, w_len_rx} > DEPTH_WORDS) w_state_next = ST_ERROR;
                    else if (w_len_rx == '0)             w_state_next = ST_CHECK;
                    else                                 w_state_next = ST_DATA;
                end else if (w_tmo_expire) begin
                    w_state_next = ST_ERROR;
                end
            end
            ST_DATA: begin
                if (rx_valid && w_last_byte && w_last_word) w_state_next = ST_CHECK;
                else if (w_tmo_expire)                      w_state_next = ST_ERROR;
            end
            ST_CHECK: begin
                if (rx_valid)          w_state_next = (rx_data == r_xor) ? ST_RUN : ST_ERROR;
                else if (w_tmo_expire) w_state_next = ST_ERROR;
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
            end
            ST_ERROR: begin
                if (w_is_sync) w_state_next = ST_LEN0;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_len_lo     <= '0;
            r_len        <= '0;
            r_word_idx   <= '0;
            r_byte_idx   <= '0;
            r_asm        <= '0;
            r_xor        <= '0;
            r_we         <= 1'b0;
            r_addr       <= BASE_ADDR;
            r_wdata      <= '0;
            r_core_rst_n <= 1'b0;
            r_boot_done  <= 1'b0;
            r_boot_err   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_we         <= 1'b0;
            // Status outputs are registered from the next state so they
            // change on the same edge that enters RUN/ERROR.
            r_core_rst_n <= (w_state_next == ST_RUN);
            r_boot_done  <= (w_state_next == ST_RUN);
            r_boot_err   <= (w_state_next == ST_ERROR);

            if (rx_valid) begin
                unique case (r_state)
                    ST_IDLE, ST_ERROR: begin
                        if (w_is_sync) begin
                            r_len_lo   <= '0;
                            r_len      <= '0;
                            r_word_idx <= '0;
                            r_byte_idx <= '0;
                            r_xor      <= '0;
                        end
                    end
                    ST_LEN0: begin
                        r_len_lo <= rx_data;
                        r_xor    <= r_xor ^ rx_data;
                    end
                    ST_LEN1: begin
                        r_len <= w_len_rx;
                        r_xor <= r_xor ^ rx_data;
                    end
                    ST_DATA: begin
                        r_xor      <= r_xor ^ rx_data;
                        r_byte_idx <= r_byte_idx + BIDX_W'(1);
                        unique case (r_byte_idx)
                            2'd0: r_asm[7:0]   <= rx_data;
                            2'd1: r_asm[15:8]  <= rx_data;
                            2'd2: r_asm[23:16] <= rx_data;
                            default: begin
                                // Byte 3 goes straight into the write word, so
                                // the assembler is free for the next word.
                                r_we       <= 1'b1;
                                r_wdata    <= {rx_data, r_asm};
                                r_addr     <= word_addr(BASE_ADDR, r_word_idx);
                                r_word_idx <= r_word_idx + LEN_W'(1);
                            end
                        endcase
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign core_rst_n = r_core_rst_n;
    assign boot_done  = r_boot_done;
    assign boot_err   = r_boot_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [7:0]  SYNC  = 8'hA5;
    localparam int unsigned TMO   = 40;

    localparam int OUT_PEND = 0;
    localparam int OUT_RUN  = 1;
    localparam int OUT_ERR  = 2;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        boot_done;
    logic        boot_err;

    imem_boot_loader #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .SYNC_BYTE   (SYNC),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .boot_done  (boot_done),
        .boot_err   (boot_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] stim[$];
    int         exp_out;
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor, sampled just after the active edge.
    always @(posedge clk) begin
        #1;
        if (imem_we === 1'b1) got_q.push_back('{addr: imem_addr, data: imem_wdata, cyc: cyc});
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"},    32'(imem_we),    32'd0);
        check({tag, "_addr"},  imem_addr,       BASE);
        check({tag, "_wdata"}, imem_wdata,      32'd0);
        check({tag, "_crst"},  32'(core_rst_n), 32'd0);
        check({tag, "_done"},  32'(boot_done),  32'd0);
        check({tag, "_err"},   32'(boot_err),   32'd0);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Drives stim[] one byte per cycle with 0..gap_max idle cycles between
    // bytes; returns one cycle after the last byte was presented.
    task automatic send_stim(input int gap_max);
        int g;
        for (int i = 0; i < stim.size(); i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = stim[i];
            g = (i == stim.size() - 1) ? 0 : int'($urandom_range(gap_max, 0));
            repeat (g) begin
                @(negedge clk);
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic build(input int n, input bit bad, input int junk);
        logic [7:0] b;
        logic [7:0] x;
        logic [7:0] lo;
        logic [7:0] hi;
        stim.delete();
        repeat (junk) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h00;
            stim.push_back(b);
        end
        lo = n[7:0];
        hi = n[15:8];
        stim.push_back(SYNC);
        stim.push_back(lo);
        stim.push_back(hi);
        x = lo ^ hi;
        repeat (n * 4) begin
            b = 8'($urandom);
            x ^= b;
            stim.push_back(b);
        end
        if (bad) x ^= 8'($urandom_range(255, 1));
        stim.push_back(x);
    endtask

    // Reference: parse the byte list as a frame and list the memory writes
    // and the final outcome it implies.
    task automatic model();
        int          i;
        int          n;
        logic [7:0]  x;
        logic [31:0] w;
        exp_q.delete();
        exp_out = OUT_PEND;
        i = 0;
        while (i < stim.size() && stim[i] != SYNC) i++;
        i++;
        if (i + 1 >= stim.size()) return;
        n = int'(stim[i]) + 256 * int'(stim[i+1]);
        x = stim[i] ^ stim[i+1];
        i += 2;
        if (n > int'(DEPTH)) begin
            exp_out = OUT_ERR;
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (i + 4 > stim.size()) return;
            w = {stim[i+3], stim[i+2], stim[i+1], stim[i]};
            x ^= stim[i] ^ stim[i+1] ^ stim[i+2] ^ stim[i+3];
            exp_q.push_back('{addr: BASE + 32'(4 * k), data: w, cyc: 0});
            i += 4;
        end
        if (i >= stim.size()) return;
        exp_out = (stim[i] == x) ? OUT_RUN : OUT_ERR;
    endtask

    task automatic check_outcome(input string tag);
        check({tag, "_nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            check($sformatf("%s_addr%0d", tag, k), got_q[k].addr, exp_q[k].addr);
            check($sformatf("%s_data%0d", tag, k), got_q[k].data, exp_q[k].data);
        end
        check({tag, "_done"}, 32'(boot_done),  32'(exp_out == OUT_RUN));
        check({tag, "_crst"}, 32'(core_rst_n), 32'(exp_out == OUT_RUN));
        check({tag, "_err"},  32'(boot_err),   32'(exp_out == OUT_ERR));
    endtask

    initial begin
        int n;
        // Reset state
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        got_q.delete();

        // Two-word frame; XOR of LEN and data bytes is 0x92
        stim = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
        model();
        send_stim(1);
        check_outcome("plan");
        check("plan_n", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("plan_w0", got_q[0].data, 32'h0000_0013);
            check("plan_a0", got_q[0].addr, 32'h0000_0000);
            check("plan_w1", got_q[1].data, 32'h0010_0093);
            check("plan_a1", got_q[1].addr, 32'h0000_0004);
        end

        // RUN ignores further traffic, including SYNC
        stim = {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_stim(0);
        check("run_ign_n",    32'(got_q.size()), 32'd2);
        check("run_ign_done", 32'(boot_done),    32'd1);
        check("run_ign_err",  32'(boot_err),     32'd0);

        // Asynchronous reset out of RUN, checked away from any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("run_arst_crst", 32'(core_rst_n), 32'd0);
        check("run_arst_done", 32'(boot_done),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();

        // Bad checksum, then recovery with a correct frame
        stim = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'h83};
        model();
        send_stim(0);
        check_outcome("badchk");
        got_q.delete();
        stim = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
        model();
        void'(stim.pop_front());
        send_byte(SYNC);
        check("err_clr", 32'(boot_err), 32'd0);
        send_stim(1);
        check_outcome("recover");

        // Zero-length frame: RUN one cycle after CHK, no writes
        do_reset();
        stim = {8'hA5, 8'h00, 8'h00, 8'h00};
        model();
        send_stim(0);
        check_outcome("zero");

        // Oversize (65 words) and largest legal (64 words)
        do_reset();
        stim = {8'hA5, 8'h41, 8'h00};
        model();
        send_stim(0);
        check_outcome("oversize");
        do_reset();
        build(64, 1'b0, 0);
        model();
        send_stim(0);
        check_outcome("len64");

        // Timeout inside a partial word
        do_reset();
        stim = {8'hA5, 8'h02, 8'h00, 8'h13};
        send_stim(0);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_early_err", 32'(boot_err), 32'd0);
        @(negedge clk);
        check("tmo_err",  32'(boot_err),     32'd1);
        check("tmo_crst", 32'(core_rst_n),   32'd0);
        check("tmo_nwr",  32'(got_q.size()), 32'd0);

        // Back-to-back bytes with leading junk 00 FF
        do_reset();
        build(5, 1'b0, 0);
        stim.push_front(8'hFF);
        stim.push_front(8'h00);
        model();
        send_stim(0);
        check_outcome("b2b");
        for (int k = 1; k < got_q.size(); k++)
            check($sformatf("b2b_gap%0d", k), 32'(got_q[k].cyc - got_q[k-1].cyc), 32'd4);

        // Asynchronous reset mid-DATA, while a write pulse is high
        do_reset();
        stim = {8'hA5, 8'h04, 8'h00, 8'h37, 8'h05, 8'h00, 8'h00};
        send_stim(0);
        check("mid_we", 32'(imem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("mid_arst");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized frames
        for (int it = 0; it < 12; it++) begin
            do_reset();
            n = ($urandom_range(4, 0) == 0) ? 0 : int'($urandom_range(12, 1));
            build(n, ($urandom_range(3, 0) == 0), int'($urandom_range(3, 0)));
            model();
            send_stim(int'($urandom_range(3, 0)));
            check_outcome($sformatf("rnd%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
